// File: rtl/elbeth_core.sv
// elbeth_core: non-pipelined multi-cycle RV32I subset core (FETCH -> EXEC -> MEM).
// Word-addressed instruction and data ports with ready handshakes; 8-bit word addresses.
module elbeth_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [7:0]  imem_addr,
    output logic [31:0] imem_in_data,
    output logic [3:0]  imem_rw,
    input  logic [31:0] imem_out_data,
    input  logic        imem_ready,
    output logic        dmem_en,
    output logic [7:0]  dmem_addr,
    output logic [31:0] dmem_in_data,
    output logic [3:0]  dmem_rw,
    input  logic [31:0] dmem_out_data,
    input  logic        dmem_ready
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        MEM
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_next;
    logic [XLEN-1:0]   ir;
    logic              ir_load;
    logic [XLEN-1:0]   regs [NREGS];

    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_s;
    logic [XLEN-1:0]   imm_b;
    logic [XLEN-1:0]   imm_j;
    logic [XLEN-1:0]   imm_u;

    logic [XLEN-1:0]   alu_b;
    logic [XLEN-1:0]   alu_res;
    logic              alu_valid;

    logic              wr_en;
    logic [XLEN-1:0]   wr_data;
    logic              mem_start;
    logic              is_store;
    logic [7:0]        ea_word;

    // Instruction field decode
    assign opcode  = ir[6:0];
    assign rd      = ir[11:7];
    assign funct3  = ir[14:12];
    assign rs1     = ir[19:15];
    assign rs2     = ir[24:20];
    assign funct7  = ir[31:25];
    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign imm_i   = {{20{ir[31]}}, ir[31:20]};
    assign imm_s   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign imm_u   = {ir[31:12], 12'h000};

    assign is_store = (opcode == OP_STORE);
    assign ea_word  = 8'((rs1_val + (is_store ? imm_s : imm_i)) >> 2);

    // Port drive; instruction port never writes
    assign imem_en      = (state == FETCH) && !rst;
    assign imem_addr    = pc[9:2];
    assign imem_in_data = '0;
    assign imem_rw      = 4'b0000;
    assign dmem_en      = (state == MEM);

    // ALU for register-immediate and register-register forms; unsupported encodings stay invalid
    always_comb begin
        alu_b     = (opcode == OP_REG) ? rs2_val : imm_i;
        alu_res   = '0;
        alu_valid = 1'b0;
        if ((opcode == OP_IMM) || ((opcode == OP_REG) && (funct7 == 7'h00))) begin
            alu_valid = 1'b1;
            case (funct3)
                3'b000:  alu_res = rs1_val + alu_b;
                3'b010:  alu_res = XLEN'($signed(rs1_val) < $signed(alu_b));
                3'b100:  alu_res = rs1_val ^ alu_b;
                3'b110:  alu_res = rs1_val | alu_b;
                3'b111:  alu_res = rs1_val & alu_b;
                default: alu_valid = 1'b0;
            endcase
        end else if ((opcode == OP_REG) && (funct7 == 7'h20) && (funct3 == 3'b000)) begin
            alu_valid = 1'b1;
            alu_res   = rs1_val - rs2_val;
        end
    end

    // Next-state, PC and register write control
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_load    = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        mem_start  = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    ir_load    = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = FETCH;
                pc_next    = pc + 32'd4;
                case (opcode)
                    OP_LUI: begin
                        wr_en   = 1'b1;
                        wr_data = imm_u;
                    end
                    OP_JAL: begin
                        wr_en   = 1'b1;
                        wr_data = pc + 32'd4;
                        pc_next = pc + imm_j;
                    end
                    OP_BRANCH: begin
                        if (((funct3 == 3'b000) && (rs1_val == rs2_val)) ||
                            ((funct3 == 3'b001) && (rs1_val != rs2_val))) begin
                            pc_next = pc + imm_b;
                        end
                    end
                    OP_LOAD, OP_STORE: begin
                        if (funct3 == 3'b010) begin
                            mem_start  = 1'b1;
                            pc_next    = pc;
                            state_next = MEM;
                        end
                    end
                    default: begin
                        wr_en   = alu_valid;
                        wr_data = alu_res;
                    end
                endcase
            end
            MEM: begin
                if (dmem_ready) begin
                    state_next = FETCH;
                    pc_next    = pc + 32'd4;
                    wr_en      = !is_store;
                    wr_data    = dmem_out_data;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            ir <= '0;
        end else begin
            pc <= pc_next;
            if (ir_load) begin
                ir <= imem_out_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (rd != 5'd0)) begin
            regs[rd] <= wr_data;
        end
    end

    // Data-port request fields are captured once in EXEC and held through MEM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_addr    <= '0;
            dmem_rw      <= 4'h0;
            dmem_in_data <= '0;
        end else if (mem_start) begin
            dmem_addr    <= ea_word;
            dmem_rw      <= is_store ? 4'hF : 4'h0;
            dmem_in_data <= rs2_val;
        end
    end

endmodule

// File: tb/tb_elbeth_core.sv
// Self-checking bench for elbeth_core: instruction-level reference model plus
// directed reset/handshake scenarios and randomized programs with random memory latency.
module tb_elbeth_core;

    logic        clk;
    logic        rst;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_in_data;
    logic [3:0]  imem_rw;
    logic [31:0] imem_out_data;
    logic        imem_ready;
    logic        dmem_en;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_in_data;
    logic [3:0]  dmem_rw;
    logic [31:0] dmem_out_data;
    logic        dmem_ready;

    elbeth_core dut (
        .clk(clk), .rst(rst),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_in_data(imem_in_data),
        .imem_rw(imem_rw), .imem_out_data(imem_out_data), .imem_ready(imem_ready),
        .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_in_data(dmem_in_data),
        .dmem_rw(dmem_rw), .dmem_out_data(dmem_out_data), .dmem_ready(dmem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    assign imem_out_data = imem[imem_addr];
    assign dmem_out_data = dmem[dmem_addr];

    int vectors = 0;
    int errors  = 0;

    // Reference architectural state
    logic [31:0] m_reg [32];
    logic [31:0] m_pc;
    int          stage;       // 0 fetch expected, 1 execute gap, 2 data transfer expected
    logic        m_mem;
    logic        m_load;
    logic [4:0]  m_rd;
    logic [7:0]  m_addr;
    logic [31:0] m_data;

    // Memory latency control: lat < 0 means random 0..3 cycles
    int i_lat, d_lat, i_cnt, d_cnt, i_tgt, d_tgt;
    bit junk;

    logic        s_imem_en, s_dmem_en;
    logic [7:0]  s_imem_addr, s_dmem_addr;
    logic [31:0] s_dmem_in_data;
    logic [3:0]  s_dmem_rw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    // Arithmetic/logic result by funct3; returns 0 in ok for encodings outside the subset
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, output bit ok);
        ok = 1'b1;
        case (f3)
            3'd0:    return a + b;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd6:    return a | b;
            3'd7:    return a & b;
            default: begin ok = 1'b0; return 32'd0; end
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_pc  = 32'd0;
        stage = 0;
        m_mem = 1'b0;
        i_cnt = 0;
        d_cnt = 0;
    endtask

    // Execute one instruction architecturally at the moment its fetch completes
    task automatic model_exec();
        logic [31:0] ins, a, b, res, nxt;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        bit          wr;
        ins = imem[m_pc[9:2]];
        op  = ins[6:0];
        rd  = ins[11:7];
        f3  = ins[14:12];
        f7  = ins[31:25];
        a   = m_reg[ins[19:15]];
        b   = m_reg[ins[24:20]];
        nxt = m_pc + 32'd4;
        wr  = 1'b0;
        res = 32'd0;
        m_mem = 1'b0;
        case (op)
            7'h37: begin wr = 1'b1; res = {ins[31:12], 12'h000}; end
            7'h6f: begin
                wr  = 1'b1;
                res = m_pc + 32'd4;
                nxt = m_pc + {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'h63: begin
                if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b))
                    nxt = m_pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'h03: if (f3 == 3'd2) begin
                m_mem  = 1'b1;
                m_load = 1'b1;
                m_rd   = rd;
                m_addr = 8'((a + sext12(ins[31:20])) >> 2);
            end
            7'h23: if (f3 == 3'd2) begin
                m_mem  = 1'b1;
                m_load = 1'b0;
                m_data = b;
                m_addr = 8'((a + sext12({ins[31:25], ins[11:7]})) >> 2);
            end
            7'h13: res = alu(f3, a, sext12(ins[31:20]), wr);
            7'h33: begin
                if (f7 == 7'h00) res = alu(f3, a, b, wr);
                else if (f7 == 7'h20 && f3 == 3'd0) begin wr = 1'b1; res = a - b; end
            end
            default: ;
        endcase
        if (wr && rd != 5'd0) m_reg[rd] = res;
        if (!m_mem) m_pc = nxt;
        stage = 1;
    endtask

    // One clock: sample and compare at the falling edge, then drive ready for the next rising edge
    task automatic run_cycle();
        @(negedge clk);
        s_imem_en      = imem_en;
        s_imem_addr    = imem_addr;
        s_dmem_en      = dmem_en;
        s_dmem_addr    = dmem_addr;
        s_dmem_rw      = dmem_rw;
        s_dmem_in_data = dmem_in_data;
        chk("imem_en", 32'(imem_en), 32'(stage == 0));
        chk("dmem_en", 32'(dmem_en), 32'(stage == 2));
        chk("imem_wr", {imem_in_data[31:4], imem_in_data[3:0] | imem_rw}, 32'd0);
        if (stage == 0) chk("imem_addr", 32'(imem_addr), 32'(m_pc[9:2]));
        if (stage == 2) begin
            chk("dmem_addr", 32'(dmem_addr), 32'(m_addr));
            chk("dmem_rw", 32'(dmem_rw), m_load ? 32'h0 : 32'hF);
            if (!m_load) chk("dmem_in_data", dmem_in_data, m_data);
        end
        imem_ready = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        dmem_ready = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        case (stage)
            0: begin
                if (i_cnt == 0) i_tgt = (i_lat < 0) ? int'($urandom_range(0, 3)) : i_lat;
                if (i_cnt == i_tgt) begin
                    imem_ready = 1'b1;
                    i_cnt = 0;
                    model_exec();
                end else begin
                    imem_ready = 1'b0;
                    i_cnt++;
                end
            end
            1: stage = m_mem ? 2 : 0;
            default: begin
                if (d_cnt == 0) d_tgt = (d_lat < 0) ? int'($urandom_range(0, 3)) : d_lat;
                if (d_cnt == d_tgt) begin
                    dmem_ready = 1'b1;
                    d_cnt = 0;
                    if (m_load) begin
                        if (m_rd != 5'd0) m_reg[m_rd] = dmem[m_addr];
                    end else begin
                        dmem[m_addr] = m_data;
                    end
                    m_pc  = m_pc + 32'd4;
                    m_mem = 1'b0;
                    stage = 0;
                end else begin
                    dmem_ready = 1'b0;
                    d_cnt++;
                end
            end
        endcase
    endtask

    // Assert reset mid-cycle and check that the ports fall back immediately
    task automatic async_reset_check(input string tag);
        #2 rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk({tag, "_imem_en"}, 32'(imem_en), 32'd0);
        chk({tag, "_dmem_en"}, 32'(dmem_en), 32'd0);
        chk({tag, "_dmem_rw"}, 32'(dmem_rw), 32'd0);
        chk({tag, "_addrs"}, {16'd0, imem_addr, dmem_addr}, 32'd0);
        chk({tag, "_dmem_in_data"}, dmem_in_data, 32'd0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, r1, r2;
        int off;
        rd  = 5'($urandom_range(0, 7));
        r1  = 5'($urandom_range(0, 7));
        r2  = 5'($urandom_range(0, 7));
        off = (int'($urandom_range(0, 32)) - 16) * 4;
        case ($urandom_range(0, 13))
            0:  return {20'($urandom), rd, 7'h37};
            1:  return enc_j(21'(off), rd);
            2:  return enc_b(13'(off), r2, r1, 3'($urandom_range(0, 1)));
            3:  return enc_i(12'($urandom), r1, 3'd2, rd, 7'h03);
            4:  return enc_s(12'($urandom), r2, r1);
            5, 6, 7: return enc_i(12'($urandom), r1, 3'($urandom), rd, 7'h13);
            8, 9:   return enc_r(7'h00, r2, r1, 3'($urandom), rd);
            10: return enc_r(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, r2, r1, 3'd0, rd);
            11: return $urandom;
            12: return enc_b(13'($urandom) & 13'h00FE, r2, r1, 3'($urandom));
            default: return enc_i(12'($urandom_range(0, 40)), r1, 3'd0, rd, 7'h13);
        endcase
    endfunction

    initial begin
        rst        = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        junk       = 1'b0;
        i_lat      = 0;
        d_lat      = 0;
        model_reset();
        clear_imem();
        for (int i = 0; i < 256; i++) dmem[i] = 32'd0;

        // Reset state and directed ALU/SW/LW program
        #3;
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        chk("rst_dmem_en", 32'(dmem_en), 32'd0);
        chk("rst_dmem_rw", 32'(dmem_rw), 32'd0);
        imem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        imem[1] = enc_i(12'd7, 5'd1, 3'd0, 5'd2, 7'h13);
        imem[2] = enc_s(12'd64, 5'd2, 5'd0);
        imem[3] = enc_i(12'd64, 5'd0, 3'd2, 5'd3, 7'h03);
        imem[4] = enc_s(12'd68, 5'd3, 5'd0);
        imem[5] = enc_i(12'd9, 5'd0, 3'd0, 5'd0, 7'h13);
        imem[6] = enc_s(12'd0, 5'd0, 5'd0);
        release_reset();
        run_cycle();
        chk("c1_imem_en", 32'(s_imem_en), 32'd1);
        chk("c1_imem_addr", 32'(s_imem_addr), 32'h00);
        repeat (6) run_cycle();
        chk("c7_dmem_en", 32'(s_dmem_en), 32'd1);
        chk("c7_dmem_addr", 32'(s_dmem_addr), 32'h10);
        chk("c7_dmem_rw", 32'(s_dmem_rw), 32'hF);
        chk("c7_dmem_in_data", s_dmem_in_data, 32'd12);
        d_lat = 3;
        repeat (2) run_cycle();
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            chk("lw_hold", {s_imem_en, s_dmem_en, 10'd0, s_dmem_rw, 8'd0, s_dmem_addr},
                {1'b0, 1'b1, 10'd0, 4'h0, 8'd0, 8'h10});
        end
        d_lat = 0;
        repeat (3) run_cycle();
        chk("lw_val_addr", 32'(s_dmem_addr), 32'h11);
        chk("lw_val_data", s_dmem_in_data, 32'd12);
        repeat (5) run_cycle();
        chk("x0_store_data", s_dmem_in_data, 32'd0);

        // Branches: BNE not taken, BEQ x0,x0,-4 at PC 8
        async_reset_check("rst2");
        clear_imem();
        imem[0] = enc_b(13'd8, 5'd0, 5'd0, 3'd1);
        imem[1] = enc_i(12'd1, 5'd0, 3'd0, 5'd5, 7'h13);
        imem[2] = enc_b(13'h1FFC, 5'd0, 5'd0, 3'd0);
        release_reset();
        repeat (3) run_cycle();
        chk("bne_next", 32'(s_imem_addr), 32'h01);
        repeat (2) run_cycle();
        chk("beq_pc8", 32'(s_imem_addr), 32'h02);
        repeat (2) run_cycle();
        chk("beq_target", 32'(s_imem_addr), 32'h01);

        // Reset during a stalled store aborts it; registers return to 0
        async_reset_check("rst3");
        clear_imem();
        imem[0] = enc_i(12'd33, 5'd0, 3'd0, 5'd1, 7'h13);
        imem[1] = enc_s(12'd4, 5'd1, 5'd0);
        d_lat = 10;
        release_reset();
        repeat (6) run_cycle();
        chk("stall_dmem_en", 32'(s_dmem_en), 32'd1);
        async_reset_check("abort");
        imem[0] = enc_s(12'd8, 5'd1, 5'd0);
        d_lat = 0;
        release_reset();
        run_cycle();
        chk("restart_addr", 32'(s_imem_addr), 32'h00);
        repeat (2) run_cycle();
        chk("restart_x1", s_dmem_in_data, 32'd0);
        chk("restart_daddr", 32'(s_dmem_addr), 32'h02);

        // Randomized programs, memory latency and ready noise
        junk  = 1'b1;
        i_lat = -1;
        d_lat = -1;
        for (int round = 0; round < 6; round++) begin
            async_reset_check("rnd");
            for (int i = 0; i < 256; i++) begin
                imem[i] = rand_instr();
                dmem[i] = $urandom;
            end
            release_reset();
            repeat (600) run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
